// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states, access-mode constants and address helpers for data_mem_ctrl
package data_mem_pkg;
    typedef enum logic [2:0] {IDLE, RD_FETCH, RD_OUT, WR_FETCH, WR_MERGE, WR_STORE, ERASE} state_t;
    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
    function automatic int unsigned row_of(input int unsigned adrs, input int unsigned lane_w);
        return adrs >> lane_w;
    endfunction
    function automatic int unsigned lane_of(input int unsigned adrs, input int unsigned lane_w);
        return adrs & ((32'd1 << lane_w) - 32'd1);
    endfunction
endpackage

// File: rtl/data_mem_lane_merge.sv
// data_mem_lane_merge: replaces one byte lane of a word, or the whole word for wide stores
module data_mem_lane_merge #(
    parameter int WORD_BYTES = 4,
    parameter int BYTE_W = 8,
    localparam int LANE_W = $clog2(WORD_BYTES),
    localparam int WORD_W = WORD_BYTES * BYTE_W
) (
    input  logic [WORD_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wide,
    output logic [WORD_W-1:0] merged
);
    always_comb begin
        merged = word;
        merged[lane*BYTE_W +: BYTE_W] = wdata[BYTE_W-1:0];
        merged = wide ? wdata : merged;
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked byte/word data memory with read-modify-write stores and row-sweep erase
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORD_BYTES = 4,
    parameter int BYTE_W = 8,
    localparam int DEPTH = (2 ** ADDR_W) / WORD_BYTES,
    localparam int LANE_W = $clog2(WORD_BYTES),
    localparam int WORD_W = WORD_BYTES * BYTE_W,
    localparam int ROW_W = ADDR_W - LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              erase,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic              req_wide,
    input  logic [ADDR_W-1:0] req_adrs,
    input  logic [WORD_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);
    state_t state, state_n;
    logic erase_pend, lat_mode, lat_wide, mis;
    logic [ROW_W-1:0] cnt, row;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] lat_adrs;
    logic [WORD_W-1:0] lat_data, temp, merged;
    logic [WORD_W-1:0] mem [DEPTH];

    assign row = ROW_W'(row_of(32'(lat_adrs), LANE_W));
    assign lane = LANE_W'(lane_of(32'(lat_adrs), LANE_W));
    assign mis = lat_wide && lane != '0;
    assign req_ready = state == IDLE && !erase_pend && !erase;
    assign busy = state != IDLE;

    data_mem_lane_merge #(.WORD_BYTES(WORD_BYTES), .BYTE_W(BYTE_W)) u_merge (
        .word(temp), .lane(lane), .wdata(lat_data), .wide(lat_wide), .merged(merged)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ERASE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = erase_pend ? ERASE :
                                (req_valid && req_ready) ? (req_mode == MODE_WRITE ? WR_FETCH : RD_FETCH) : IDLE;
            RD_FETCH: state_n = RD_OUT;
            RD_OUT:   state_n = IDLE;
            WR_FETCH: state_n = WR_MERGE;
            WR_MERGE: state_n = WR_STORE;
            WR_STORE: state_n = IDLE;
            ERASE:    state_n = &cnt ? IDLE : ERASE;
            default:  state_n = IDLE;
        endcase
    end

    // erase requests seen during the sweep are absorbed by it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erase_pend <= 1'b0;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_data <= '0;
            lat_mode <= 1'b0;
            lat_wide <= 1'b0;
            lat_adrs <= '0;
            lat_data <= '0;
            temp <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (erase && state != ERASE) erase_pend <= 1'b1;
            if (state == IDLE && req_valid && req_ready) begin
                lat_mode <= req_mode;
                lat_wide <= req_wide;
                lat_adrs <= req_adrs;
                lat_data <= req_data;
            end
            case (state)
                ERASE: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) erase_pend <= 1'b0;
                end
                RD_FETCH, WR_FETCH: temp <= mem[row];
                WR_MERGE: temp <= merged;
                RD_OUT: begin
                    rsp_valid <= 1'b1;
                    rsp_err <= mis;
                    rsp_data <= mis ? '0 : lat_wide ? temp : WORD_W'(temp[lane*BYTE_W +: BYTE_W]);
                end
                WR_STORE: begin
                    rsp_valid <= 1'b1;
                    rsp_err <= mis;
                    rsp_data <= mis ? '0 : temp;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk)
        if (state == ERASE) mem[cnt] <= '0;
        else if (state == WR_STORE && !mis && lat_mode == MODE_WRITE) mem[row] <= temp;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed checks of data_mem_ctrl against a byte-array model
module tb_data_mem_ctrl;
    logic clk = 0, rst = 1, erase = 0, valid = 0, mode = 0, wide = 0, sel = 0;
    logic [7:0] adrs = 0;
    logic [63:0] wdata = 0;
    logic rdy_a, rv_a, re_a, busy_a, rdy_b, rv_b, re_b, busy_b;
    logic [31:0] rd_a;
    logic [63:0] rd_b;
    logic rdy, rv, re, busy;
    logic [63:0] rd;
    int total = 0, bad = 0;
    int wb = 4, aw = 6, depth = 16;
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    data_mem_ctrl dut_a (
        .clk(clk), .rst(rst), .erase(erase && !sel), .req_valid(valid && !sel), .req_ready(rdy_a),
        .req_mode(mode), .req_wide(wide), .req_adrs(adrs[5:0]), .req_data(wdata[31:0]),
        .rsp_valid(rv_a), .rsp_data(rd_a), .rsp_err(re_a), .busy(busy_a)
    );

    data_mem_ctrl #(.ADDR_W(8), .WORD_BYTES(8), .BYTE_W(8)) dut_b (
        .clk(clk), .rst(rst), .erase(erase && sel), .req_valid(valid && sel), .req_ready(rdy_b),
        .req_mode(mode), .req_wide(wide), .req_adrs(adrs), .req_data(wdata),
        .rsp_valid(rv_b), .rsp_data(rd_b), .rsp_err(re_b), .busy(busy_b)
    );

    assign rdy = sel ? rdy_b : rdy_a;
    assign rv = sel ? rv_b : rv_a;
    assign re = sel ? re_b : re_a;
    assign busy = sel ? busy_b : busy_a;
    assign rd = sel ? rd_b : {32'b0, rd_a};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    function automatic logic [63:0] mread(input int a, input bit w);
        logic [63:0] r = 64'h0;
        if (!w) return {56'b0, ref_mem[a]};
        if (a % wb != 0) return 64'h0;
        for (int i = 0; i < wb; i++) r[8*i +: 8] = ref_mem[a+i];
        return r;
    endfunction

    task automatic accept(input logic m, input logic w, input logic [7:0] a, input logic [63:0] d, output bit ok);
        mode = m; wide = w; adrs = a; wdata = d; valid = 1; ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = rdy;
            tick();
        end
        valid = 0;
        if (!ok) check("accept_timeout", rdy, 1);
    endtask

    task automatic finish_rsp(input int erase_at, output logic [63:0] got, output logic err, output int lat);
        lat = 0;
        do begin
            erase = (lat == erase_at);
            tick();
            lat++;
        end while (!rv && lat < 20);
        erase = 0;
        got = rd;
        err = re;
        if (!rv) check("rsp_timeout", rv, 1);
    endtask

    task automatic do_op(input logic m, input logic w, input logic [7:0] a, input logic [63:0] d, input int erase_at = -1);
        bit ok, mis;
        logic [63:0] got, exp;
        logic err;
        int lat, ai, base;
        ai = int'(a);
        base = ai - ai % wb;
        mis = w && (ai % wb != 0);
        accept(m, w, a, d, ok);
        finish_rsp(erase_at, got, err, lat);
        if (m && !mis) begin
            if (w) for (int i = 0; i < wb; i++) ref_mem[base+i] = d[8*i +: 8];
            else ref_mem[ai] = d[7:0];
        end
        exp = mis ? 64'h0 : m ? mread(base, 1) : mread(ai, w);
        check($sformatf("%s_data@%0h", m ? "wr" : "rd", a), got, exp);
        check($sformatf("%s_err@%0h", m ? "wr" : "rd", a), err, mis);
        check($sformatf("%s_lat@%0h", m ? "wr" : "rd", a), lat, m ? 3 : 2);
    endtask

    task automatic rand_ops(input int n);
        for (int k = 0; k < n; k++) begin
            logic m, w;
            int ai;
            m = 1'($urandom % 2);
            w = 1'($urandom % 2);
            ai = int'($urandom_range(0, (1 << aw) - 1));
            if (w && $urandom % 4 != 0) ai = ai - ai % wb;
            do_op(m, w, 8'(ai), {$urandom, $urandom});
        end
    endtask

    task automatic sweep_check(input string tag);
        int n = 0;
        bit seen_rdy = 0, seen_rv = 0;
        while (busy && n < 200) begin
            n++;
            seen_rdy |= rdy;
            seen_rv |= rv_a | rv_b;
            tick();
        end
        check({tag, "_len"}, n, depth);
        check({tag, "_rdy"}, seen_rdy, 0);
        check({tag, "_no_rsp"}, seen_rv, 0);
        clear_model();
    endtask

    initial begin
        bit ok;
        clear_model();
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_ready", rdy, 0);
        check("rst_rsp_valid", rv, 0);
        check("rst_rsp_data", rd, 0);
        check("rst_rsp_err", re, 0);
        rst = 0;
        sweep_check("sweep_a");
        do_op(0, 1, 8'h10, 0);
        do_op(1, 0, 8'h05, 64'hAA);
        do_op(1, 0, 8'h06, 64'h55);
        do_op(0, 1, 8'h04, 0);
        do_op(1, 1, 8'h3C, 64'hDEADBEEF);
        do_op(0, 0, 8'h3E, 0);
        do_op(1, 1, 8'h20, 64'h12345678);
        do_op(1, 1, 8'h21, 64'hCAFEF00D);
        do_op(0, 1, 8'h20, 0);
        rand_ops(60);
        do_op(1, 0, 8'h09, 64'h5A, 1);
        check("pend_blocks_ready", rdy, 0);
        tick();
        sweep_check("sweep_merge");
        for (int r = 0; r < depth; r++) do_op(0, 1, 8'(r * wb), 0);
        rand_ops(20);
        mode = 0; wide = 1; adrs = 0; valid = 1; erase = 1;
        #1;
        check("erase_blocks_ready", rdy, 0);
        tick();
        valid = 0; erase = 0;
        tick();
        sweep_check("sweep_coinc");
        rand_ops(10);
        accept(1, 1, 8'h00, 64'h11223344, ok);
        rst = 1;
        #1;
        check("abort_busy", busy_a, 1);
        check("abort_ready", rdy_a, 0);
        check("abort_rsp_valid", rv_a, 0);
        sel = 1; wb = 8; aw = 8; depth = 32;
        repeat (2) tick();
        rst = 0;
        sweep_check("sweep_b");
        do_op(1, 1, 8'h18, 64'h0123456789ABCDEF);
        for (int i = 0; i < 8; i++) do_op(0, 0, 8'(8'h18 + i), 0);
        do_op(1, 0, 8'h1D, 64'h77);
        do_op(0, 1, 8'h18, 0);
        do_op(0, 1, 8'h1C, 0);
        rand_ops(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked successor to the team's fixed 64x8 data memory. Byte-addressed storage is organised as words of WORD_BYTES lanes. Reads take 2 cycles and writes take 3 cycles through a read-modify-write sequence. Whole-word access, misalignment error reporting, and a row-sweeping erase that also runs automatically out of reset are added. It sits between the processor datapath load/store stage and its private data store.

## Interface
Parameters:
- ADDR_W, 6, byte-address width; total capacity 2**ADDR_W bytes.
- WORD_BYTES, 4, lanes per row; power of two, at least 2.
- BYTE_W, 8, bits per lane.
- Derived values (not overridable):
  - DEPTH = 2**ADDR_W / WORD_BYTES rows.
  - LANE_W = log2(WORD_BYTES).
  - WORD_W = WORD_BYTES*BYTE_W.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- erase  in  1  erase request; one-cycle pulse is sufficient.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_mode  in  1  0 = read, 1 = write.
- req_wide  in  1  0 = single-byte access, 1 = whole-word access.
- req_adrs  in  ADDR_W  byte address; row = adrs[ADDR_W-1:LANE_W], lane = adrs[LANE_W-1:0].
- req_data  in  WORD_W  write data; the byte write uses [BYTE_W-1:0].
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_data  out  WORD_W  read result, or the merged row after a write.
- rsp_err  out  1  valid with rsp_valid; set for a misaligned wide access.
- busy  out  1  high whenever the FSM state is not IDLE.

## Operation
- States:
  - IDLE.
  - RD_FETCH, RD_OUT.
  - WR_FETCH, WR_MERGE, WR_STORE.
  - ERASE.
- req_ready = (state == IDLE) && !erase_pend && !erase. Erase beats a simultaneous request; that request is not accepted.
- On acceptance, the controller latches mode, wide, adrs and data.
- Read path:
  - RD_FETCH: temp <= row[row_idx].
  - RD_OUT: rsp_data <= the selected lane zero-extended for a byte read, or temp for a wide read; rsp_valid is set; next state IDLE.
- Write path:
  - WR_FETCH: temp <= row.
  - WR_MERGE: replace only the addressed lane with req_data[BYTE_W-1:0]; a wide write replaces all lanes.
  - WR_STORE: row <= temp; rsp_data <= temp; rsp_valid is set; next state IDLE.
- Misaligned access (req_wide=1 with a nonzero lane):
  - The request follows the same state sequence and latency.
  - A write does not modify the array.
  - The response has rsp_data=0 and rsp_err=1.
- Erase:
  - erase is latched into erase_pend in any state, so it is never lost mid-operation.
  - The sweep starts from IDLE when erase_pend is set. It clears one row per cycle for rows 0..DEPTH-1, then returns to IDLE and clears erase_pend.
  - An erase that arrives during the sweep is absorbed by the sweep in progress.
- Reset values:
  - state = ERASE, sweep counter = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0, erase_pend = 0.
  - busy = 1 and req_ready = 0 for DEPTH cycles after reset release.
  - Array contents are guaranteed zero only after the sweep finishes.
- Reset asserted mid-operation aborts the transaction with no response, then restarts the erase sweep.

## Timing
- Read accepted at edge T: rsp_valid is high in the cycle following edge T+2 (2-cycle latency).
- Write accepted at edge T: the array is updated and rsp_valid is high after edge T+3 (3-cycle latency).
- req_ready rises in the same cycle as rsp_valid, so back-to-back throughput is one read per 3 cycles and one write per 4 cycles.
- A read of a row written by the immediately preceding write returns the new data; WR_STORE completes before the next acceptance.
- Erase: DEPTH cycles in ERASE plus 1 cycle of IDLE before req_ready can rise.
- rsp_valid is a single-cycle pulse with no backpressure; rsp_data and rsp_err hold their values until the next response.

## Structure
- Package data_mem_pkg:
  - state enum.
  - MODE_READ/MODE_WRITE constants.
  - Helper functions for row/lane extraction from an address.
- Sub-module data_mem_lane_merge: combinational lane replace (word, lane, byte, wide) -> word. It is used in WR_MERGE and is reusable by future wider-store variants.
- The array is a single reg array [DEPTH] of WORD_W bits. The array itself has no reset; it is cleared only by the ERASE sweep.

## Test plan
- Reset release, then poll: busy stays 1 for 16 cycles (defaults) and req_ready stays 0; then a wide read of address 0x10 returns 0x00000000.
- Byte writes 0xAA to 0x05 and 0x55 to 0x06, then a wide read of 0x04 -> rsp_data 0x0055AA00 with rsp_err=0. Write acks arrive exactly 3 cycles after acceptance and the read response 2 cycles after acceptance.
- Wide write 0xDEADBEEF to 0x3C, then byte read of 0x3E -> 0x000000AD.
- Wide write to 0x21 (misaligned) -> rsp_err=1 and rsp_data=0; a subsequent wide read of 0x20 still returns the previous contents.
- erase pulsed during WR_MERGE: the write completes and acks, ERASE follows for DEPTH cycles, and all rows then read 0. An erase coincident with req_valid in IDLE -> request not accepted.
- rst asserted mid-write at WR_FETCH -> no rsp_valid, the FSM re-enters ERASE, and the bench re-runs with WORD_BYTES=8, ADDR_W=8 to check the 32-cycle sweep and lane mapping.
